// File: rtl/uart_core.sv
// UART core: bus-strobed TX/RX FIFOs, 16x oversampled serial TX and RX, and status/interrupt logic.
// Macro UART_FIFO_EN: when defined, TX and RX FIFOs are 8 deep; otherwise each FIFO is a single holding register.
// Ports:
//   sysclk, rst       clock and synchronous active-high reset
//   uart_datain       TX byte written on the falling edge of uart_wrh_n
//   uart_ctrlin       bit0 rx_ie, bit1 tx_ie, bit2 loopback
//   uart_wrh_n        TX write strobe (active low)
//   uart_rdh_n        RX data read strobe (active low); pops on its rising edge
//   uart_rdl_n        status read strobe (active low); clears error flags on its rising edge
//   uart_dataout      RX FIFO head, 8'h00 when empty (combinational)
//   uart_ctrlout      {3'b0, rx_ferr, rx_ovr, tx_idle, tx_full, rx_avail}
//   uart_int          registered interrupt request
//   rxd, txd          serial input (asynchronous) and serial output (idle high)
module uart_core #(
    parameter int unsigned BAUD_DIV = 13
) (
    input  logic       sysclk,
    input  logic       rst,
    input  logic [7:0] uart_datain,
    input  logic [7:0] uart_ctrlin,
    input  logic       uart_wrh_n,
    input  logic       uart_rdh_n,
    input  logic       uart_rdl_n,
    output logic [7:0] uart_dataout,
    output logic [7:0] uart_ctrlout,
    output logic       uart_int,
    input  logic       rxd,
    output logic       txd
);
`ifdef UART_FIFO_EN
    localparam int unsigned DEPTH = 8;
`else
    localparam int unsigned DEPTH = 1;
`endif
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned DW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    logic          rx_ie, tx_ie, loopback, unused_ctrl;
    logic          wrh_q, rdh_q, rdl_q, wr_req, rd_rise, rdl_rise;
    logic [DW-1:0] div_cnt;
    logic          tick;
    logic [7:0]    tx_mem [DEPTH];
    logic [7:0]    rx_mem [DEPTH];
    logic [AW-1:0] tx_wptr, tx_rptr, rx_wptr, rx_rptr;
    logic [CW-1:0] tx_count, rx_count;
    logic          tx_empty, tx_full, rx_empty, rx_full;
    logic          tx_push, tx_pop, rx_push, rx_pop;
    state_t        tx_state, tx_next, rx_state, rx_next;
    logic [3:0]    tx_cnt, rx_cnt;
    logic [2:0]    tx_idx, rx_idx;
    logic [7:0]    tx_shift, rx_shift;
    logic          tx_bit_end, tx_line, tx_ser, tx_idle;
    logic          rx_s1, rx_s2, rx_prev, rx_sample, rx_stop_ok, ferr_set, ovr_set;
    logic          rx_ovr, rx_ferr;

    assign rx_ie       = uart_ctrlin[0];
    assign tx_ie       = uart_ctrlin[1];
    assign loopback    = uart_ctrlin[2];
    assign unused_ctrl = ^uart_ctrlin[7:3];

    // Bus strobe registers and edge detection
    always_ff @(posedge sysclk) begin
        if (rst) begin
            wrh_q  <= 1'b1;
            rdh_q  <= 1'b1;
            rdl_q  <= 1'b1;
            wr_req <= 1'b0;
        end else begin
            wrh_q  <= uart_wrh_n;
            rdh_q  <= uart_rdh_n;
            rdl_q  <= uart_rdl_n;
            wr_req <= wrh_q && !uart_wrh_n;
        end
    end
    assign rd_rise  = !rdh_q && uart_rdh_n;
    assign rdl_rise = !rdl_q && uart_rdl_n;

    // Free-running oversample divider
    always_ff @(posedge sysclk) begin
        if (rst || tick) div_cnt <= '0;
        else             div_cnt <= div_cnt + DW'(1);
    end
    assign tick = (div_cnt == DW'(BAUD_DIV - 1));

    // FIFO flags; a push into a full FIFO is accepted only when the same cycle pops
    assign tx_empty = (tx_count == '0);
    assign tx_full  = (tx_count == CW'(DEPTH));
    assign rx_empty = (rx_count == '0);
    assign rx_full  = (rx_count == CW'(DEPTH));
    assign tx_push  = wr_req && (!tx_full || tx_pop);
    assign rx_pop   = rd_rise && !rx_empty;
    assign rx_push  = rx_stop_ok && (!rx_full || rx_pop);
    assign ovr_set  = rx_stop_ok && rx_full && !rx_pop;

    // FIFO storage
    always_ff @(posedge sysclk) begin
        if (tx_push) tx_mem[tx_wptr] <= uart_datain;
        if (rx_push) rx_mem[rx_wptr] <= rx_shift;
    end

    // FIFO pointers and occupancy counts
    always_ff @(posedge sysclk) begin
        if (rst) begin
            tx_wptr  <= '0;
            tx_rptr  <= '0;
            tx_count <= '0;
            rx_wptr  <= '0;
            rx_rptr  <= '0;
            rx_count <= '0;
        end else begin
            if (tx_push) tx_wptr <= ptr_inc(tx_wptr);
            if (tx_pop)  tx_rptr <= ptr_inc(tx_rptr);
            if (tx_push && !tx_pop)      tx_count <= tx_count + CW'(1);
            else if (!tx_push && tx_pop) tx_count <= tx_count - CW'(1);
            if (rx_push) rx_wptr <= ptr_inc(rx_wptr);
            if (rx_pop)  rx_rptr <= ptr_inc(rx_rptr);
            if (rx_push && !rx_pop)      rx_count <= rx_count + CW'(1);
            else if (!rx_push && rx_pop) rx_count <= rx_count - CW'(1);
        end
    end

    // TX FSM: state register
    always_ff @(posedge sysclk) begin
        if (rst) tx_state <= S_IDLE;
        else     tx_state <= tx_next;
    end

    assign tx_bit_end = tick && (tx_cnt == 4'd15);

    // TX FSM: next state; frames leave IDLE on a tick so every bit spans exactly 16 ticks
    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            S_IDLE:  if (tick && !tx_empty) tx_next = S_START;
            S_START: if (tx_bit_end) tx_next = S_DATA;
            S_DATA:  if (tx_bit_end && tx_idx == 3'd7) tx_next = S_STOP;
            S_STOP:  if (tx_bit_end) tx_next = tx_empty ? S_IDLE : S_START;
            default: tx_next = S_IDLE;
        endcase
    end

    // TX FSM: outputs; the end of STOP chains straight into the next frame
    always_comb begin
        tx_pop  = 1'b0;
        tx_line = 1'b1;
        case (tx_state)
            S_IDLE:  tx_pop  = tick && !tx_empty;
            S_START: tx_line = 1'b0;
            S_DATA:  tx_line = tx_shift[0];
            S_STOP:  tx_pop  = tx_bit_end && !tx_empty;
            default: ;
        endcase
    end

    // TX bit timing and shift register
    always_ff @(posedge sysclk) begin
        if (rst) begin
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
        end else if (tx_pop) begin
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shift <= tx_mem[tx_rptr];
        end else if (tick && tx_state != S_IDLE) begin
            tx_cnt <= tx_cnt + 4'd1;
            if (tx_bit_end && tx_state == S_DATA) begin
                tx_shift <= {1'b0, tx_shift[7:1]};
                tx_idx   <= tx_idx + 3'd1;
            end
        end
    end

    // Serial line registers; loopback reroutes the TX line to RX and parks txd high
    always_ff @(posedge sysclk) begin
        if (rst) begin
            tx_ser <= 1'b1;
            txd    <= 1'b1;
        end else begin
            tx_ser <= tx_line;
            txd    <= loopback ? 1'b1 : tx_line;
        end
    end

    // RX input synchronizer and edge history
    always_ff @(posedge sysclk) begin
        if (rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= loopback ? tx_ser : rxd;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    // RX FSM: state register
    always_ff @(posedge sysclk) begin
        if (rst) rx_state <= S_IDLE;
        else     rx_state <= rx_next;
    end

    assign rx_sample = tick && (rx_cnt == 4'd15);

    // RX FSM: next state; IDLE needs a fresh 1->0 edge, so after a framing error it waits for the line to go high
    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            S_IDLE:  if (rx_prev && !rx_s2) rx_next = S_START;
            S_START: if (tick && rx_cnt == 4'd7) rx_next = rx_s2 ? S_IDLE : S_DATA;
            S_DATA:  if (rx_sample && rx_idx == 3'd7) rx_next = S_STOP;
            S_STOP:  if (rx_sample) rx_next = S_IDLE;
            default: rx_next = S_IDLE;
        endcase
    end

    // RX FSM: stop-bit outcome
    always_comb begin
        rx_stop_ok = 1'b0;
        ferr_set   = 1'b0;
        if (rx_state == S_STOP && rx_sample) begin
            rx_stop_ok = rx_s2;
            ferr_set   = !rx_s2;
        end
    end

    // RX bit timing; the counter restarts at mid start bit so data samples land mid bit
    always_ff @(posedge sysclk) begin
        if (rst) begin
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_shift <= '0;
        end else begin
            case (rx_state)
                S_IDLE: begin
                    rx_cnt <= '0;
                    rx_idx <= '0;
                end
                S_START: if (tick) rx_cnt <= (rx_cnt == 4'd7) ? 4'd0 : rx_cnt + 4'd1;
                S_DATA: if (tick) begin
                    rx_cnt <= rx_cnt + 4'd1;
                    if (rx_cnt == 4'd15) begin
                        rx_shift <= {rx_s2, rx_shift[7:1]};
                        rx_idx   <= rx_idx + 3'd1;
                    end
                end
                S_STOP: if (tick) rx_cnt <= rx_cnt + 4'd1;
                default: ;
            endcase
        end
    end

    // Sticky error flags and interrupt; a set in the clearing cycle wins
    always_ff @(posedge sysclk) begin
        if (rst) begin
            rx_ovr   <= 1'b0;
            rx_ferr  <= 1'b0;
            uart_int <= 1'b0;
        end else begin
            if (ovr_set)       rx_ovr <= 1'b1;
            else if (rdl_rise) rx_ovr <= 1'b0;
            if (ferr_set)      rx_ferr <= 1'b1;
            else if (rdl_rise) rx_ferr <= 1'b0;
            uart_int <= (rx_ie && !rx_empty) || (tx_ie && tx_idle) || rx_ovr || rx_ferr;
        end
    end

    assign tx_idle      = tx_empty && (tx_state == S_IDLE);
    assign uart_dataout = rx_empty ? 8'h00 : rx_mem[rx_rptr];
    assign uart_ctrlout = {3'b000, rx_ferr, rx_ovr, tx_idle, tx_full, !rx_empty};

endmodule

// File: tb/tb_uart_core.sv
// Directed testbench for uart_core: reset, TX framing, loopback, overrun, framing error, glitch, TX full, reset mid-frame.
module tb_uart_core;
    localparam int BD    = 4;
    localparam int BIT   = 16 * BD;
    localparam int FRAME = 10 * BIT;
`ifdef UART_FIFO_EN
    localparam int DEPTH = 8;
`else
    localparam int DEPTH = 1;
`endif

    logic       sysclk = 1'b0;
    logic       rst;
    logic [7:0] uart_datain;
    logic [7:0] uart_ctrlin;
    logic       uart_wrh_n;
    logic       uart_rdh_n;
    logic       uart_rdl_n;
    logic [7:0] uart_dataout;
    logic [7:0] uart_ctrlout;
    logic       uart_int;
    logic       rxd;
    logic       txd;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         low_cycles = 0;
    logic [8:0] txq[$];

    uart_core #(.BAUD_DIV(BD)) dut (
        .sysclk       (sysclk),
        .rst          (rst),
        .uart_datain  (uart_datain),
        .uart_ctrlin  (uart_ctrlin),
        .uart_wrh_n   (uart_wrh_n),
        .uart_rdh_n   (uart_rdh_n),
        .uart_rdl_n   (uart_rdl_n),
        .uart_dataout (uart_dataout),
        .uart_ctrlout (uart_ctrlout),
        .uart_int     (uart_int),
        .rxd          (rxd),
        .txd          (txd)
    );

    always #5 sysclk = ~sysclk;

    task automatic cyc(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [7:0] d);
        uart_datain = d;
        uart_wrh_n  = 1'b0;
        cyc(5);
        uart_wrh_n  = 1'b1;
        cyc(2);
    endtask

    task automatic bus_read();
        uart_rdh_n = 1'b0;
        cyc(3);
        uart_rdh_n = 1'b1;
        cyc(2);
    endtask

    task automatic status_read();
        uart_rdl_n = 1'b0;
        cyc(3);
        uart_rdl_n = 1'b1;
        cyc(2);
    endtask

    task automatic send_rx(input logic [7:0] d, input logic stop);
        rxd = 1'b0;
        cyc(BIT);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            cyc(BIT);
        end
        rxd = stop;
        cyc(BIT);
        rxd = 1'b1;
        cyc(BIT / 4);
    endtask

    // Count every cycle txd is low
    always @(posedge sysclk) begin
        if (txd === 1'b0) low_cycles <= low_cycles + 1;
    end

    // Decode frames on txd into {stop, data}, sampling mid bit
    initial begin : tx_mon
        logic [7:0] d;
        logic       s;
        forever begin
            cyc(1);
            if (txd === 1'b0) begin
                cyc(BIT / 2);
                for (int i = 0; i < 8; i++) begin
                    cyc(BIT);
                    d[i] = txd;
                end
                cyc(BIT);
                s = txd;
                txq.push_back({s, d});
            end
        end
    end

    initial begin : main
        int         t;
        int         lc0;
        logic [8:0] e;

        rst         = 1'b1;
        uart_datain = 8'h00;
        uart_ctrlin = 8'h00;
        uart_wrh_n  = 1'b1;
        uart_rdh_n  = 1'b1;
        uart_rdl_n  = 1'b1;
        rxd         = 1'b1;
        cyc(2);
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_status", 32'(uart_ctrlout), 32'h04);
        check("rst_int", 32'(uart_int), 32'd0);
        check("rst_dataout", 32'(uart_dataout), 32'h00);
        rst = 1'b0;
        cyc(4);

        // Single TX frame of A5
        txq.delete();
        lc0 = low_cycles;
        bus_write(8'hA5);
        t = 0;
        while (txq.size() == 0 && t < 3 * FRAME) begin
            cyc(1);
            t++;
        end
        check("tx_frame_seen", 32'(t < 3 * FRAME), 32'd1);
        cyc(2 * FRAME);
        check("tx_frame_count", 32'(txq.size()), 32'd1);
        e = (txq.size() > 0) ? txq[0] : 9'h000;
        check("tx_frame_byte", 32'(e), 32'h1A5);
        check("tx_low_cycles", 32'(low_cycles - lc0), 32'(5 * BIT));
        check("tx_idle_after", 32'(uart_ctrlout[2]), 32'd1);

        // Loopback of 3C with rx interrupt enabled
        uart_ctrlin = 8'h05;
        cyc(2);
        lc0 = low_cycles;
        bus_write(8'h3C);
        t = 0;
        while (uart_ctrlout[0] !== 1'b1 && t < 3 * FRAME) begin
            cyc(1);
            t++;
        end
        check("lb_rx_seen", 32'(t < 3 * FRAME), 32'd1);
        cyc(2);
        check("lb_dataout", 32'(uart_dataout), 32'h3C);
        check("lb_int", 32'(uart_int), 32'd1);
        t = 0;
        while (uart_ctrlout[2] !== 1'b1 && t < 2 * FRAME) begin
            cyc(1);
            t++;
        end
        check("lb_txd_held", 32'(low_cycles - lc0), 32'd0);
        bus_read();
        check("lb_rx_avail_clr", 32'(uart_ctrlout[0]), 32'd0);
        check("lb_dataout_empty", 32'(uart_dataout), 32'h00);
        check("lb_int_clr", 32'(uart_int), 32'd0);
        uart_ctrlin = 8'h00;
        cyc(4);

        // RX overrun: DEPTH+1 bytes without reads
        for (int i = 1; i <= DEPTH + 1; i++) send_rx(8'(i), 1'b1);
        cyc(4);
        check("ovr_flag", 32'(uart_ctrlout[3]), 32'd1);
        check("ovr_int", 32'(uart_int), 32'd1);
        for (int i = 1; i <= DEPTH; i++) begin
            check("ovr_order", 32'(uart_dataout), 32'(i));
            bus_read();
        end
        check("ovr_drained", 32'(uart_ctrlout[0]), 32'd0);
        check("ovr_sticky", 32'(uart_ctrlout[3]), 32'd1);
        status_read();
        check("ovr_clear", 32'(uart_ctrlout[3]), 32'd0);
        cyc(2);
        check("ovr_int_clr", 32'(uart_int), 32'd0);

        // Framing error on 55, then a one-tick glitch, then a good byte
        send_rx(8'h55, 1'b0);
        cyc(4);
        check("ferr_flag", 32'(uart_ctrlout[4]), 32'd1);
        check("ferr_empty", 32'(uart_ctrlout[0]), 32'd0);
        check("ferr_int", 32'(uart_int), 32'd1);
        status_read();
        check("ferr_clear", 32'(uart_ctrlout[4]), 32'd0);
        rxd = 1'b0;
        cyc(BD);
        rxd = 1'b1;
        cyc(2 * BIT);
        check("glitch_status", 32'(uart_ctrlout), 32'h04);
        send_rx(8'h96, 1'b1);
        cyc(4);
        check("post_glitch_byte", 32'(uart_dataout), 32'h96);
        bus_read();

        // TX full: one frame in flight, DEPTH queued, one dropped
        txq.delete();
        bus_write(8'h10);
        cyc(BD + 2);
        check("txf_first_popped", 32'(uart_ctrlout[1]), 32'd0);
        for (int k = 1; k <= DEPTH; k++) bus_write(8'(16 + k));
        check("txf_full", 32'(uart_ctrlout[1]), 32'd1);
        bus_write(8'hEE);
        check("txf_still_full", 32'(uart_ctrlout[1]), 32'd1);
        t = 0;
        while (txq.size() < DEPTH + 1 && t < (DEPTH + 3) * FRAME) begin
            cyc(1);
            t++;
        end
        check("txf_frames_seen", 32'(t < (DEPTH + 3) * FRAME), 32'd1);
        cyc(2 * FRAME);
        check("txf_frame_count", 32'(txq.size()), 32'(DEPTH + 1));
        for (int k = 0; k <= DEPTH; k++) begin
            e = (k < txq.size()) ? txq[k] : 9'h000;
            check("txf_order", 32'(e), 32'({1'b1, 8'(16 + k)}));
        end
        check("txf_idle", 32'(uart_ctrlout[2]), 32'd1);

        // Reset in the middle of a TX frame
        bus_write(8'h00);
        t = 0;
        while (txd !== 1'b0 && t < 2 * FRAME) begin
            cyc(1);
            t++;
        end
        check("rstmid_started", 32'(t < 2 * FRAME), 32'd1);
        cyc(BIT);
        rst = 1'b1;
        cyc(1);
        check("rstmid_txd", 32'(txd), 32'd1);
        check("rstmid_status", 32'(uart_ctrlout), 32'h04);
        rst = 1'b0;
        lc0 = low_cycles;
        cyc(2 * FRAME);
        check("rstmid_no_resume", 32'(low_cycles - lc0), 32'd0);
        check("rstmid_rx_empty", 32'(uart_dataout), 32'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
